// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: tagged instruction prefetch FIFO in front of the SPI RAM controller
module inst_prefetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] ADDR_STEP = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_valid,
  output logic [15:0] fetch_data,
  output logic        fetch_pending,
  output logic [15:0] ram_addr,
  output logic        ram_start_read,
  input  logic [15:0] ram_data_out,
  input  logic        ram_busy,
  output logic [2:0]  level
);
  typedef enum logic [1:0] {IDLE, ISSUE, SKIP, WAIT} state_t;
  state_t      state_q, state_d;
  logic [15:0] tag_q [DEPTH];
  logic [15:0] tag_d [DEPTH];
  logic [15:0] data_q [DEPTH];
  logic [15:0] data_d [DEPTH];
  logic [3:0]  level_q, level_d, popn;
  logic [15:0] next_addr_q, next_addr_d, ram_addr_q, ram_addr_d;
  logic [15:0] addr_q, addr_d, fetch_data_q, fetch_data_d, eff_addr, hit_data;
  logic        pending_q, pending_d, fetch_valid_q, fetch_valid_d, discard_q, discard_d;
  logic        inflight, done, active, hit, hold, flush, push, issue;
  // A fresh request is looked up in its own cycle so hits return the next cycle
  always_comb begin
    inflight = state_q != IDLE;
    done     = state_q == WAIT && !ram_busy;
    active   = pending_q || fetch_req;
    eff_addr = pending_q ? addr_q : fetch_addr;
    hit      = 1'b0;
    popn     = '0;
    hit_data = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (active && 4'(i) < level_q && tag_q[i] == eff_addr) begin
        hit      = 1'b1;
        popn     = 4'(i + 1);
        hit_data = data_q[i];
      end
    hold  = active && !hit && level_q == 0 &&
            ((inflight && !discard_q && ram_addr_q == eff_addr) || next_addr_q == eff_addr);
    flush = active && !hit && !hold;
    push  = done && !discard_q && !flush;
    issue = state_q == IDLE && enable && (flush || level_q < 4'(DEPTH));
    state_d = state_q == IDLE  ? (issue ? ISSUE : IDLE) :
              state_q == ISSUE ? SKIP :
              state_q == SKIP  ? WAIT : (done ? IDLE : WAIT);
    ram_addr_d    = issue ? (flush ? eff_addr : next_addr_q) : ram_addr_q;
    next_addr_d   = issue ? ram_addr_d + ADDR_STEP : (flush ? eff_addr : next_addr_q);
    discard_d     = !done && (discard_q || (flush && inflight));
    pending_d     = active && !hit;
    addr_d        = active ? eff_addr : addr_q;
    fetch_valid_d = hit;
    fetch_data_d  = hit ? hit_data : fetch_data_q;
    level_d       = flush ? '0 : level_q - popn + {3'b0, push};
    for (int i = 0; i < DEPTH; i++) begin
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
      for (int j = 0; j < DEPTH; j++)
        if (j == i + int'(popn)) begin
          tag_d[i]  = tag_q[j];
          data_d[i] = data_q[j];
        end
      if (push && i == int'(level_q) - int'(popn)) begin
        tag_d[i]  = ram_addr_q;
        data_d[i] = ram_data_out;
      end
    end
  end
  // Control and status registers with synchronous active-low reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q       <= IDLE;
      level_q       <= '0;
      next_addr_q   <= '0;
      ram_addr_q    <= '0;
      addr_q        <= '0;
      fetch_data_q  <= '0;
      pending_q     <= 1'b0;
      fetch_valid_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      next_addr_q   <= next_addr_d;
      ram_addr_q    <= ram_addr_d;
      addr_q        <= addr_d;
      fetch_data_q  <= fetch_data_d;
      pending_q     <= pending_d;
      fetch_valid_q <= fetch_valid_d;
      discard_q     <= discard_d;
    end
  // Entry storage needs no reset; level_q alone marks valid entries
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
  assign fetch_valid    = fetch_valid_q;
  assign fetch_data     = fetch_data_q;
  assign fetch_pending  = pending_q;
  assign ram_addr       = ram_addr_q;
  assign ram_start_read = state_q == ISSUE && rst_n;
  assign level          = level_q[2:0];
  a_no_req_while_pending: assert property (@(posedge clk) disable iff (!rst_n) !(fetch_req && pending_q));
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb_inst_prefetch_buffer: directed checks of the prefetch buffer against a 20-cycle stub SPI RAM
module tb_inst_prefetch_buffer;
  logic        clk = 0, rst_n = 0, enable = 1, fetch_req = 0, ram_busy;
  logic [15:0] fetch_addr = 0, fetch_data, ram_addr, ram_data_out;
  logic        fetch_valid, fetch_pending, ram_start_read;
  logic [2:0]  level;
  logic [15:0] strobes[$];
  int          busy_cnt = 0, checks = 0, errors = 0, base = 0;
  always #5 clk = ~clk;
  inst_prefetch_buffer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_pending(fetch_pending),
    .ram_addr(ram_addr), .ram_start_read(ram_start_read), .ram_data_out(ram_data_out),
    .ram_busy(ram_busy), .level(level)
  );
  // Stub RAM: busy for 20 cycles after each strobe, returns addr ^ A5A5
  assign ram_busy = busy_cnt != 0;
  always @(posedge clk)
    if (ram_start_read) begin
      busy_cnt <= 20;
      ram_data_out <= ram_addr ^ 16'hA5A5;
      strobes.push_back(ram_addr);
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic fetch(input logic [15:0] a);
    fetch_req = 1; fetch_addr = a;
    @(negedge clk);
    fetch_req = 0;
  endtask
  task automatic wait_level(input int n, input string tag);
    for (int i = 0; i < 600 && level != 3'(n); i++) @(negedge clk);
    chk(tag, 32'(level), 32'(n));
  endtask
  task automatic wait_strobes(input int n, input string tag);
    for (int i = 0; i < 300 && strobes.size() < n; i++) @(negedge clk);
    chk(tag, 32'(strobes.size() >= n), 1);
  endtask
  task automatic wait_fv(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 300 && !fetch_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, 32'(fetch_valid), 1);
    chk(tag, 32'(fetch_data), 32'(exp));
  endtask
  task automatic do_reset();
    rst_n = 0;
    cyc(2);
    base = strobes.size();
    rst_n = 1;
  endtask
  initial begin
    cyc(2);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_data", 32'(fetch_data), 0);
    chk("rst_pending", 32'(fetch_pending), 0);
    chk("rst_strobe", 32'(ram_start_read), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    base = strobes.size();
    rst_n = 1;
    wait_level(4, "t1_full");
    for (int i = 0; i < 4; i++) chk("t1_order", 32'(strobes[base + i]), 32'(i));
    cyc(40);
    chk("t1_no5th", 32'(strobes.size() - base), 4);
    chk("t1_level", 32'(level), 4);
    fetch(16'h0000);
    chk("t2_valid", 32'(fetch_valid), 1);
    chk("t2_data", 32'(fetch_data), 32'hA5A5);
    chk("t2_level", 32'(level), 3);
    chk("t2_pending", 32'(fetch_pending), 0);
    wait_strobes(base + 5, "t2_strobe");
    chk("t2_addr4", 32'(strobes[base + 4]), 4);
    do_reset();
    wait_level(4, "t3_full");
    fetch(16'h0002);
    chk("t3_valid", 32'(fetch_valid), 1);
    chk("t3_data", 32'(fetch_data), 32'hA5A7);
    chk("t3_level", 32'(level), 1);
    fetch(16'h0003);
    chk("t3_tag3", 32'(fetch_data), 32'hA5A6);
    chk("t3_empty", 32'(level), 0);
    fetch(16'h0004);
    chk("t3_wait", 32'(fetch_pending), 1);
    wait_fv("t3_inflight", 16'hA5A1);
    wait_strobes(base + 6, "t4_strobe5");
    chk("t4_addr5", 32'(strobes[base + 5]), 5);
    cyc(3);
    fetch(16'h0100);
    chk("t4_flush", 32'(level), 0);
    for (int i = 0; i < 300 && strobes.size() < base + 7; i++) begin
      if (fetch_valid) chk("t4_early_valid", 32'(fetch_valid), 0);
      @(negedge clk);
    end
    chk("t4_strobe", 32'(strobes.size() >= base + 7), 1);
    chk("t4_addr", 32'(strobes[base + 6]), 32'h0100);
    chk("t4_dropped", 32'(level), 0);
    chk("t4_pend", 32'(fetch_pending), 1);
    wait_fv("t4_data", 16'hA4A5);
    do_reset();
    fetch(16'hFFFF);
    chk("t5_issue", 32'(ram_start_read), 1);
    chk("t5_addr", 32'(ram_addr), 32'hFFFF);
    chk("t5_pend", 32'(fetch_pending), 1);
    wait_fv("t5_data", 16'h5A5A);
    wait_strobes(base + 2, "t5_strobe2");
    chk("t5_wrap", 32'(strobes[base + 1]), 0);
    cyc(5);
    fetch(16'h2000);
    chk("t6_pend", 32'(fetch_pending), 1);
    rst_n = 0;
    cyc(1);
    chk("t6_level", 32'(level), 0);
    chk("t6_pending", 32'(fetch_pending), 0);
    chk("t6_strobe", 32'(ram_start_read), 0);
    chk("t6_addr", 32'(ram_addr), 0);
    chk("t6_data", 32'(fetch_data), 0);
    chk("t6_valid", 32'(fetch_valid), 0);
    base = strobes.size();
    rst_n = 1;
    enable = 0;
    cyc(1);
    chk("t6_strobe_after", 32'(ram_start_read), 0);
    cyc(30);
    chk("t6_stale", 32'(level), 0);
    chk("t6_no_issue", 32'(strobes.size() - base), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
